// File: rtl/clint_axi_pkg.sv
// Shared constants, FSM state types and address decode helpers for the AXI CLINT.
package clint_axi_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_ADDR    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} sel_e;

  typedef struct packed {
    sel_e        sel;
    logic [13:0] idx;
  } dec_t;

  // Only addr[15:0] is decoded; misaligned hits on any register are treated as unmapped.
  function automatic dec_t decode(input logic [15:0] off, input int unsigned nr_cores);
    dec_t        d;
    logic [16:0] rel_msip;
    logic [16:0] rel_cmp;
    d.sel    = SEL_NONE;
    d.idx    = '0;
    rel_msip = {1'b0, off} - {1'b0, MSIP_BASE};
    rel_cmp  = {1'b0, off} - {1'b0, MTIMECMP_BASE};
    if (off == MTIME_ADDR) begin
      d.sel = SEL_MTIME;
    end else if (!rel_msip[16] && rel_msip[1:0] == 2'b00 && 32'(rel_msip) < 4 * nr_cores) begin
      d.sel = SEL_MSIP;
      d.idx = rel_msip[15:2];
    end else if (!rel_cmp[16] && rel_cmp[2:0] == 3'b000 && 32'(rel_cmp) < 8 * nr_cores) begin
      d.sel = SEL_MTIMECMP;
      d.idx = rel_cmp[16:3];
    end
    return d;
  endfunction

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] data,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_rtc_sync.sv
// Brings the asynchronous rtc tick into the aclk domain and emits a one-cycle
// pulse per synchronized rising edge.
module clint_rtc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rtc,
  output logic tick
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= rtc;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign tick = sync_2 & ~sync_3;

endmodule

// File: rtl/cva6_clint_axi.sv
// Core-local interruptor (msip, mtimecmp, mtime) behind an AXI4 slave with
// independent read and write burst engines.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | accepting len+1 write beats, each applied with its byte strobes
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_DATA | rvalid high with a registered beat, advancing on rready
module cva6_clint_axi
  import clint_axi_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned NR_CORES       = 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_clint_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_clint_awaddr,
  input  logic [7:0]                  s_axi_clint_awlen,
  input  logic [2:0]                  s_axi_clint_awsize,
  input  logic [1:0]                  s_axi_clint_awburst,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi_clint_awuser,
  input  logic                        s_axi_clint_awvalid,
  output logic                        s_axi_clint_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_clint_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_clint_wstrb,
  input  logic                        s_axi_clint_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi_clint_wuser,
  input  logic                        s_axi_clint_wvalid,
  output logic                        s_axi_clint_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_clint_bid,
  output logic [1:0]                  s_axi_clint_bresp,
  output logic [AXI_USER_WIDTH-1:0]   s_axi_clint_buser,
  output logic                        s_axi_clint_bvalid,
  input  logic                        s_axi_clint_bready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_clint_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_clint_araddr,
  input  logic [7:0]                  s_axi_clint_arlen,
  input  logic [2:0]                  s_axi_clint_arsize,
  input  logic [1:0]                  s_axi_clint_arburst,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi_clint_aruser,
  input  logic                        s_axi_clint_arvalid,
  output logic                        s_axi_clint_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_clint_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_clint_rdata,
  output logic [1:0]                  s_axi_clint_rresp,
  output logic                        s_axi_clint_rlast,
  output logic [AXI_USER_WIDTH-1:0]   s_axi_clint_ruser,
  output logic                        s_axi_clint_rvalid,
  input  logic                        s_axi_clint_rready,
  input  logic                        rtc_i,
  output logic [NR_CORES-1:0]         timer_irq_o,
  output logic [NR_CORES-1:0]         ipi_o
);

  logic rst_done;
  logic tick;

  w_state_e                w_state, w_state_nxt;
  logic [AXI_ID_WIDTH-1:0] w_id;
  logic [15:0]             w_addr;
  logic [7:0]              w_len, w_cnt;
  logic [1:0]              w_burst;
  logic                    w_err;
  logic                    aw_hs, wr_en;
  dec_t                    w_dec;

  r_state_e                r_state, r_state_nxt;
  logic [AXI_ID_WIDTH-1:0] r_id;
  logic [15:0]             r_addr, r_addr_nxt, rd_addr;
  logic [7:0]              r_len, r_cnt;
  logic [1:0]              r_burst;
  logic [63:0]             r_data, rd_word;
  logic [1:0]              r_resp;
  logic                    rd_err, ar_hs, r_adv;
  dec_t                    rd_dec;

  logic [63:0]         mtime;
  logic [63:0]         mtimecmp [NR_CORES];
  logic [NR_CORES-1:0] msip;

  logic unused_ok;
  assign unused_ok = ^{s_axi_clint_awaddr[AXI_ADDR_WIDTH-1:16], s_axi_clint_araddr[AXI_ADDR_WIDTH-1:16],
                       s_axi_clint_awsize, s_axi_clint_arsize, s_axi_clint_wlast,
                       s_axi_clint_awuser, s_axi_clint_wuser, s_axi_clint_aruser};

  clint_rtc_sync u_rtc_sync (
    .clk   (aclk),
    .rst_n (aresetn),
    .rtc   (rtc_i),
    .tick  (tick)
  );

  // Holds both address channels closed for the whole reset and releases them one cycle later.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = w_state;
    s_axi_clint_awready = 1'b0;
    s_axi_clint_wready  = 1'b0;
    s_axi_clint_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_clint_awready = rst_done;
        if (s_axi_clint_awvalid && rst_done) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_clint_wready = 1'b1;
        if (s_axi_clint_wvalid && w_cnt == w_len) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_clint_bvalid = 1'b1;
        if (s_axi_clint_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt         = r_state;
    s_axi_clint_arready = 1'b0;
    s_axi_clint_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_clint_arready = rst_done;
        if (s_axi_clint_arvalid && rst_done) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi_clint_rvalid = 1'b1;
        if (s_axi_clint_rready && r_cnt == r_len) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign aw_hs = s_axi_clint_awvalid && s_axi_clint_awready;
  assign wr_en = (w_state == W_DATA) && s_axi_clint_wvalid;
  assign w_dec = decode(w_addr, NR_CORES);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi_clint_awid;
      w_addr  <= s_axi_clint_awaddr[15:0];
      w_len   <= s_axi_clint_awlen;
      w_burst <= s_axi_clint_awburst;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (wr_en) begin
      w_cnt <= w_cnt + 8'd1;
      if (w_burst != BURST_FIXED) w_addr <= w_addr + 16'd8;
      if (w_dec.sel == SEL_NONE) w_err <= 1'b1;
    end
  end

  assign s_axi_clint_bid   = w_id;
  assign s_axi_clint_bresp = w_err ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_clint_buser = '0;

  // A bus write to mtime in the tick cycle takes priority and the tick is dropped.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mtime <= '0;
    end else if (wr_en && w_dec.sel == SEL_MTIME) begin
      mtime <= strb_merge(mtime, s_axi_clint_wdata, s_axi_clint_wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int h = 0; h < NR_CORES; h++) mtimecmp[h] <= '1;
      msip        <= '0;
      timer_irq_o <= '0;
      ipi_o       <= '0;
    end else begin
      for (int h = 0; h < NR_CORES; h++) begin
        if (wr_en && w_dec.sel == SEL_MTIMECMP && w_dec.idx == 14'(h))
          mtimecmp[h] <= strb_merge(mtimecmp[h], s_axi_clint_wdata, s_axi_clint_wstrb);
        if (wr_en && w_dec.sel == SEL_MSIP && w_dec.idx == 14'(h) && s_axi_clint_wstrb[{w_addr[2], 2'b00}])
          msip[h] <= s_axi_clint_wdata[{w_addr[2], 5'b00000}];
        timer_irq_o[h] <= (mtime >= mtimecmp[h]);
      end
      ipi_o <= msip;
    end
  end

  assign r_adv      = (r_state == R_DATA) && s_axi_clint_rready && (r_cnt != r_len);
  assign r_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : r_addr + 16'd8;
  assign rd_addr    = (r_state == R_IDLE) ? s_axi_clint_araddr[15:0] : r_addr_nxt;
  assign rd_dec     = decode(rd_addr, NR_CORES);
  assign ar_hs      = s_axi_clint_arvalid && s_axi_clint_arready;

  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    case (rd_dec.sel)
      SEL_MTIME: rd_word = mtime;
      SEL_MTIMECMP: begin
        for (int h = 0; h < NR_CORES; h++) begin
          if (rd_dec.idx == 14'(h)) rd_word = mtimecmp[h];
        end
      end
      SEL_MSIP: begin
        for (int h = 0; h < NR_CORES; h++) begin
          if (rd_dec.idx == 14'(h))
            rd_word = rd_addr[2] ? {31'd0, msip[h], 32'd0} : {63'd0, msip[h]};
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

  // Each beat is sampled into registers so it stays stable while the master stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_id    <= s_axi_clint_arid;
      r_addr  <= s_axi_clint_araddr[15:0];
      r_len   <= s_axi_clint_arlen;
      r_burst <= s_axi_clint_arburst;
      r_cnt   <= '0;
      r_data  <= rd_word;
      r_resp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (r_adv) begin
      r_addr <= r_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= rd_word;
      r_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axi_clint_rid   = r_id;
  assign s_axi_clint_rdata = r_data;
  assign s_axi_clint_rresp = r_resp;
  assign s_axi_clint_rlast = s_axi_clint_rvalid && (r_cnt == r_len);
  assign s_axi_clint_ruser = '0;

endmodule

// File: tb/tb_cva6_clint_axi.sv
// Directed self-checking bench for cva6_clint_axi with a single hart.
module tb_cva6_clint_axi;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  awid = '0;
  logic [63:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd3;
  logic [1:0]  awburst = 2'b01;
  logic [0:0]  awuser = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic [0:0]  wuser = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [63:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'b01;
  logic [0:0]  aruser = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [0:0]  ruser;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        rtc_i = 1'b0;
  logic [0:0]  timer_irq_o;
  logic [0:0]  ipi_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0]  cur_id = 4'h3;
  logic        ipi_at_w;
  logic [3:0]  last_bid;
  logic [1:0]  wr_resp;
  logic [63:0] rd_data [4];
  logic [1:0]  rd_resp [4];
  logic        rd_last [4];
  logic [3:0]  rd_id [4];

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  always #5 aclk = ~aclk;

  cva6_clint_axi dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .s_axi_clint_awid    (awid),
    .s_axi_clint_awaddr  (awaddr),
    .s_axi_clint_awlen   (awlen),
    .s_axi_clint_awsize  (awsize),
    .s_axi_clint_awburst (awburst),
    .s_axi_clint_awuser  (awuser),
    .s_axi_clint_awvalid (awvalid),
    .s_axi_clint_awready (awready),
    .s_axi_clint_wdata   (wdata),
    .s_axi_clint_wstrb   (wstrb),
    .s_axi_clint_wlast   (wlast),
    .s_axi_clint_wuser   (wuser),
    .s_axi_clint_wvalid  (wvalid),
    .s_axi_clint_wready  (wready),
    .s_axi_clint_bid     (bid),
    .s_axi_clint_bresp   (bresp),
    .s_axi_clint_buser   (buser),
    .s_axi_clint_bvalid  (bvalid),
    .s_axi_clint_bready  (bready),
    .s_axi_clint_arid    (arid),
    .s_axi_clint_araddr  (araddr),
    .s_axi_clint_arlen   (arlen),
    .s_axi_clint_arsize  (arsize),
    .s_axi_clint_arburst (arburst),
    .s_axi_clint_aruser  (aruser),
    .s_axi_clint_arvalid (arvalid),
    .s_axi_clint_arready (arready),
    .s_axi_clint_rid     (rid),
    .s_axi_clint_rdata   (rdata),
    .s_axi_clint_rresp   (rresp),
    .s_axi_clint_rlast   (rlast),
    .s_axi_clint_ruser   (ruser),
    .s_axi_clint_rvalid  (rvalid),
    .s_axi_clint_rready  (rready),
    .rtc_i               (rtc_i),
    .timer_irq_o         (timer_irq_o),
    .ipi_o               (ipi_o)
  );

  task automatic axi_write(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [63:0] d0, input logic [63:0] d1, input logic [7:0] strb);
    int n;
    @(negedge aclk);
    awid = cur_id; awaddr = {48'd0, addr}; awlen = len; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL aw_handshake: awready stayed %b, required 1 within 50 cycles", awready); end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = (b == 0) ? d0 : d1; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      n_checks++;
      if (n >= 50) begin n_fail++; $display("FAIL w_handshake: wready stayed %b, required 1 within 50 cycles", wready); end
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    ipi_at_w = ipi_o[0];
    bready = 1'b1;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL b_handshake: bvalid stayed %b, required 1 within 50 cycles", bvalid); end
    wr_resp = bresp; last_bid = bid;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge aclk);
    arid = cur_id; araddr = {48'd0, addr}; arlen = len; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL ar_handshake: arready stayed %b, required 1 within 50 cycles", arready); end
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
      n_checks++;
      if (n >= 50) begin n_fail++; $display("FAIL r_handshake: rvalid stayed %b, required 1 within 50 cycles", rvalid); end
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id[b] = rid;
      @(negedge aclk);
    end
    rready = 1'b0;
  endtask

  task automatic rtc_pulse();
    @(negedge aclk);
    rtc_i = 1'b1;
    repeat (4) @(negedge aclk);
    rtc_i = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({awready, arready, bvalid, rvalid, timer_irq_o[0], ipi_o[0]} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: aw/ar/b/r/irq/ipi=%b, required 000000", {awready, arready, bvalid, rvalid, timer_irq_o[0], ipi_o[0]});
    end
    aresetn = 1'b1;
    #1;
    n_checks++;
    if ({awready, arready} !== 2'b00) begin n_fail++; $display("FAIL ready_before_edge: awready/arready=%b, required 00", {awready, arready}); end
    @(negedge aclk);
    n_checks++;
    if ({awready, arready} !== 2'b11) begin n_fail++; $display("FAIL ready_after_edge: awready/arready=%b, required 11", {awready, arready}); end
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd0 || rd_resp[0] !== OKAY || rd_last[0] !== 1'b1 || rd_id[0] !== 4'h3) begin
      n_fail++; $display("FAIL reset_mtime_read: data=%h resp=%0d last=%b id=%h, required 0/0/1/3", rd_data[0], rd_resp[0], rd_last[0], rd_id[0]);
    end
  endtask

  task automatic test_msip();
    cur_id = 4'h9;
    axi_write(16'h0000, 8'd0, INCR, 64'h1, 64'h0, 8'h0F);
    n_checks++;
    if (wr_resp !== OKAY || last_bid !== 4'h9) begin n_fail++; $display("FAIL msip_bresp: resp=%0d bid=%h, required 0/9", wr_resp, last_bid); end
    n_checks++;
    if (ipi_at_w !== 1'b0 || ipi_o[0] !== 1'b1) begin n_fail++; $display("FAIL ipi_timing: ipi at W edge=%b one cycle later=%b, required 0 then 1", ipi_at_w, ipi_o[0]); end
    axi_read(16'h0000, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'h1 || rd_resp[0] !== OKAY) begin n_fail++; $display("FAIL msip_read: data=%h resp=%0d, required 1/0", rd_data[0], rd_resp[0]); end
    axi_write(16'h0000, 8'd0, INCR, 64'h0, 64'h0, 8'hF0);
    repeat (2) @(negedge aclk);
    n_checks++;
    if (ipi_o[0] !== 1'b1) begin n_fail++; $display("FAIL msip_wrong_lane: ipi=%b, required 1", ipi_o[0]); end
    axi_write(16'h0000, 8'd0, INCR, 64'h0000_0000_FFFF_FFFE, 64'h0, 8'h0F);
    n_checks++;
    if (ipi_o[0] !== 1'b0) begin n_fail++; $display("FAIL msip_clear: ipi=%b, required 0", ipi_o[0]); end
    axi_write(16'h0000, 8'd0, INCR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F);
    axi_read(16'h0000, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'h1 || ipi_o[0] !== 1'b1) begin n_fail++; $display("FAIL msip_bit0_only: data=%h ipi=%b, required 1/1", rd_data[0], ipi_o[0]); end
  endtask

  task automatic test_timer();
    cur_id = 4'h5;
    axi_write(16'h4000, 8'd0, INCR, 64'h1122_3344_5566_7788, 64'h0, 8'hFF);
    axi_write(16'h4000, 8'd0, INCR, 64'h0, 64'h0, 8'hFE);
    axi_read(16'h4000, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'h88 || rd_resp[0] !== OKAY) begin n_fail++; $display("FAIL mtimecmp_strobe: data=%h resp=%0d, required 88/0", rd_data[0], rd_resp[0]); end
    n_checks++;
    if (timer_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL irq_below: irq=%b, required 0", timer_irq_o[0]); end
    axi_write(16'h4000, 8'd0, INCR, 64'd5, 64'h0, 8'hFF);
    repeat (4) rtc_pulse();
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd4 || timer_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL mtime_four: data=%h irq=%b, required 4/0", rd_data[0], timer_irq_o[0]); end
    @(negedge aclk);
    rtc_i = 1'b1;
    repeat (3) @(negedge aclk);
    n_checks++;
    if (timer_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL irq_early: irq=%b when mtime just became 5, required 0", timer_irq_o[0]); end
    @(negedge aclk);
    n_checks++;
    if (timer_irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL irq_set: irq=%b one cycle after mtime=5, required 1", timer_irq_o[0]); end
    rtc_i = 1'b0;
    repeat (4) @(negedge aclk);
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd5) begin n_fail++; $display("FAIL mtime_five: data=%h, required 5", rd_data[0]); end
  endtask

  task automatic test_incr_read();
    axi_read(16'h4000, 8'd1, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd5 || rd_resp[0] !== OKAY || rd_last[0] !== 1'b0) begin
      n_fail++; $display("FAIL incr_beat0: data=%h resp=%0d last=%b, required 5/0/0", rd_data[0], rd_resp[0], rd_last[0]);
    end
    n_checks++;
    if (rd_data[1] !== 64'd0 || rd_resp[1] !== SLVERR || rd_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL incr_beat1: data=%h resp=%0d last=%b, required 0/2/1", rd_data[1], rd_resp[1], rd_last[1]);
    end
  endtask

  task automatic test_unmapped_write();
    axi_write(16'h8000, 8'd0, INCR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF);
    n_checks++;
    if (wr_resp !== SLVERR) begin n_fail++; $display("FAIL unmapped_bresp: resp=%0d, required 2", wr_resp); end
    axi_read(16'h4000, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd5) begin n_fail++; $display("FAIL unmapped_cmp: mtimecmp=%h, required 5", rd_data[0]); end
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd5 || ipi_o[0] !== 1'b1 || timer_irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_state: mtime=%h ipi=%b irq=%b, required 5/1/1", rd_data[0], ipi_o[0], timer_irq_o[0]);
    end
  endtask

  task automatic test_rready_stall();
    int n;
    @(negedge aclk);
    arid = 4'hC; araddr = 64'hBFF8; arlen = 8'd0; arburst = INCR; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 64'd5 || rresp !== OKAY || rlast !== 1'b1 || rid !== 4'hC) begin
        n_fail++; $display("FAIL stall_cycle%0d: valid=%b data=%h resp=%0d last=%b id=%h, required 1/5/0/1/c", i, rvalid, rdata, rresp, rlast, rid);
      end
      @(negedge aclk);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL stall_release: rvalid=%b, required 0", rvalid); end
  endtask

  task automatic test_bursts();
    axi_write(16'hBFF8, 8'd1, FIXED, 64'd100, 64'd200, 8'hFF);
    n_checks++;
    if (wr_resp !== OKAY) begin n_fail++; $display("FAIL fixed_bresp: resp=%0d, required 0", wr_resp); end
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd200 || timer_irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL fixed_mtime: data=%h irq=%b, required c8/1", rd_data[0], timer_irq_o[0]); end
    axi_write(16'h4000, 8'd1, INCR, 64'd300, 64'd7, 8'hFF);
    n_checks++;
    if (wr_resp !== SLVERR) begin n_fail++; $display("FAIL incr_write_bresp: resp=%0d, required 2", wr_resp); end
    axi_read(16'h4000, 8'd0, INCR);
    repeat (2) @(negedge aclk);
    n_checks++;
    if (rd_data[0] !== 64'd300 || timer_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL incr_write_cmp: data=%h irq=%b, required 12c/0", rd_data[0], timer_irq_o[0]); end
    axi_write(16'hBFF8, 8'd0, INCR, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'hFF);
    rtc_pulse();
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd0) begin n_fail++; $display("FAIL mtime_wrap: data=%h, required 0", rd_data[0]); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen_b;
    @(negedge aclk);
    awid = 4'h7; awaddr = 64'h4000; awlen = 8'd0; awburst = INCR; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({awready, wready, bvalid} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_outputs: aw/w/b=%b, required 000", {awready, wready, bvalid}); end
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    seen_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (bvalid !== 1'b0) seen_b = 1'b1;
    end
    n_checks++;
    if (seen_b !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bvalid: bvalid seen=%b after release, required 0", seen_b); end
    axi_read(16'h4000, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF || rd_resp[0] !== OKAY) begin
      n_fail++; $display("FAIL mid_reset_cmp: data=%h resp=%0d, required ffffffffffffffff/0", rd_data[0], rd_resp[0]);
    end
    axi_read(16'hBFF8, 8'd0, INCR);
    n_checks++;
    if (rd_data[0] !== 64'd0 || ipi_o[0] !== 1'b0 || timer_irq_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_state: mtime=%h ipi=%b irq=%b, required 0/0/0", rd_data[0], ipi_o[0], timer_irq_o[0]);
    end
  endtask

  initial begin
    test_reset();
    test_msip();
    test_timer();
    test_incr_read();
    test_unmapped_write();
    test_rready_stall();
    test_bursts();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cva6_clint_axi.md
CVA6_CLINT_AXI -- requirements
Module: cva6_clint_axi

Interface
REQ-001 Param AXI_ADDR_WIDTH, default 64: AXI address width.
REQ-002 Param AXI_DATA_WIDTH, default 64: data width; only 64 supported.
REQ-003 Param AXI_ID_WIDTH, default 4: AXI ID width.
REQ-004 Param AXI_USER_WIDTH, default 1: user width; user inputs ignored, user outputs 0.
REQ-005 Param NR_CORES, default 1: hart count.
REQ-006 aclk in 1: sole clock, rising edge.
REQ-007 aresetn in 1: reset, asynchronous, active-low.
REQ-008 s_axi_clint_aw{id,addr,len,size,burst,valid} in, awready out: AXI4 write-address channel.
REQ-009 s_axi_clint_w{data,strb,last,valid} in, wready out: write-data channel.
REQ-010 s_axi_clint_b{id,resp,valid} out, bready in: write-response channel.
REQ-011 s_axi_clint_ar{id,addr,len,size,burst,valid} in, arready out: read-address channel.
REQ-012 s_axi_clint_r{id,data,resp,last,valid} out, rready in: read-data channel.
REQ-013 rtc_i in 1: asynchronous real-time tick.
REQ-014 timer_irq_o out NR_CORES: machine timer interrupt per hart.
REQ-015 ipi_o out NR_CORES: software interrupt per hart.

Function
REQ-016 Map, offsets from addr[15:0]: msip[h] at 0x0000+4h (bit 0 only, rest reads 0); mtimecmp[h] at 0x4000+8h; mtime at 0xBFF8; all else unmapped.
REQ-017 addr[2] selects the 32-bit lane for msip; 64-bit registers use full wdata with byte strobes.
REQ-018 mtime increments by 1, wrapping at 2^64, one cycle after each synchronized rtc_i rising edge (2-flop sync + edge detect).
REQ-019 timer_irq_o[h] registered: 1 cycle after (mtime >= mtimecmp[h]) becomes true/false.
REQ-020 ipi_o[h] equals msip[h][0] registered, 1 cycle after write.
REQ-021 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE: awready=1 only in W_IDLE; capture id/addr/len/burst on AW handshake.
REQ-022 W_DATA: wready=1; each beat applies strb; beat count len+1 ends data, wlast ignored.
REQ-023 Address advances +8 per beat for INCR and WRAP, held for FIXED; no 4 KiB check.
REQ-024 W_RESP: bvalid=1, bid=captured id, bresp=SLVERR if any beat unmapped else OKAY; held until bready.
REQ-025 Read FSM R_IDLE->R_DATA->R_IDLE: arready=1 only in R_IDLE; len+1 beats, rlast on final beat.
REQ-026 rvalid/rdata/rresp/rid stable while rvalid && !rready; unmapped beat returns 0 with SLVERR.
REQ-027 Read and write FSMs independent; same-cycle read of a register being written returns old value.
REQ-028 Write to mtime in the tick cycle: written value wins, tick lost.
REQ-029 Unmapped writes have no side effect.

Reset
REQ-030 On aresetn low: mtime=0, mtimecmp[*]=all-ones, msip[*]=0, timer_irq_o=0, ipi_o=0, FSMs idle, bvalid=rvalid=0, awready=arready=0 while asserted.
REQ-031 Reset mid-transaction aborts it; no response issued after deassertion.
REQ-032 awready/arready rise the first cycle after aresetn deasserts.

Structure
REQ-033 Package clint_axi_pkg holds offset constants (MSIP_BASE, MTIMECMP_BASE, MTIME_ADDR), FSM state enums, resp codes.
REQ-034 One sub-module clint_rtc_sync: synchronizer + rising-edge pulse.

Verification
REQ-035 Reset, no traffic -> timer_irq_o=0, ipi_o=0; read 0xBFF8 returns 0, OKAY.
REQ-036 Write 0x1 to 0x0000 strb 0x0F -> bresp OKAY, ipi_o[0]=1 one cycle after W handshake.
REQ-037 mtimecmp[0]=5, 5 rtc_i edges -> timer_irq_o[0]=1 one cycle after mtime reaches 5.
REQ-038 INCR read len=1 at 0x4000 -> 2 beats, rlast on 2nd, rresp OKAY then SLVERR (0x4008 unmapped for NR_CORES=1).
REQ-039 Write to 0x8000 -> bresp SLVERR, no register changes; rready held low 10 cycles -> R beat stable.
REQ-040 aresetn low during W_DATA -> no bvalid after release; mtimecmp[0] reads all-ones.
